// File: rtl/regfile_write_buffer.sv
// Register-file write buffer: FIFO of pending writes drained onto one registered write port.
// Optional REGFILE_WRITE_COALESCE_EN merges same-address writes into the youngest entry.
module regfile_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_in_valid,
    output logic                     io_in_ready,
    input  logic [ADDR_W-1:0]        io_in_address,
    input  logic [DATA_W-1:0]        io_in_value,
    input  logic [7:0]               io_in_byteMask,
    input  logic                     io_drain_enable,
    output logic                     io_write_write,
    output logic [ADDR_W-1:0]        io_write_address,
    output logic [DATA_W-1:0]        io_write_value,
    output logic                     io_write_byteMask_0,
    output logic                     io_write_byteMask_1,
    output logic                     io_write_byteMask_2,
    output logic                     io_write_byteMask_3,
    output logic                     io_write_byteMask_4,
    output logic                     io_write_byteMask_5,
    output logic                     io_write_byteMask_6,
    output logic                     io_write_byteMask_7,
    output logic [$clog2(DEPTH):0]   io_count,
    output logic                     io_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = DATA_W / 8;

    logic [ADDR_W-1:0] q_addr [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [7:0]        q_mask [DEPTH];

    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;

    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [7:0]        wr_mask;
    logic              wr_en;

    logic full;
    logic accept;
    logic nz;
    logic pop;
    logic merge;
    logic push;

    assign full        = (count == CW'(DEPTH));
    assign io_in_ready = !full;
    assign accept      = io_in_valid && !full;
    assign nz          = |io_in_byteMask;
    assign pop         = io_drain_enable && (count != '0);

`ifdef REGFILE_WRITE_COALESCE_EN
    logic [PW-1:0]     yng;
    logic [DATA_W-1:0] mrg_data;

    assign yng = tail + {PW{1'b1}};

    // The youngest entry may not be merged while it is leaving as head.
    assign merge = accept && nz && (count != '0)
                && (q_addr[yng] == io_in_address)
                && !((count == CW'(1)) && pop);

    always_comb begin
        mrg_data = q_data[yng];
        for (int i = 0; i < 8; i++) begin
            if (io_in_byteMask[i]) begin
                mrg_data[BW*i +: BW] = io_in_value[BW*i +: BW];
            end
        end
    end
`else
    assign merge = 1'b0;
`endif

    assign push = accept && nz && !merge;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_addr[i] <= '0;
                q_data[i] <= '0;
                q_mask[i] <= '0;
            end
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_mask <= '0;
        end else begin
            if (push) begin
                q_addr[tail] <= io_in_address;
                q_data[tail] <= io_in_value;
                q_mask[tail] <= io_in_byteMask;
                tail         <= tail + PW'(1);
            end
`ifdef REGFILE_WRITE_COALESCE_EN
            if (merge) begin
                q_data[yng] <= mrg_data;
                q_mask[yng] <= q_mask[yng] | io_in_byteMask;
            end
`endif
            if (pop) begin
                wr_en   <= 1'b1;
                wr_addr <= q_addr[head];
                wr_data <= q_data[head];
                wr_mask <= q_mask[head];
                head    <= head + PW'(1);
            end else begin
                wr_en   <= 1'b0;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign io_write_write      = wr_en;
    assign io_write_address    = wr_addr;
    assign io_write_value      = wr_data;
    assign io_write_byteMask_0 = wr_mask[0];
    assign io_write_byteMask_1 = wr_mask[1];
    assign io_write_byteMask_2 = wr_mask[2];
    assign io_write_byteMask_3 = wr_mask[3];
    assign io_write_byteMask_4 = wr_mask[4];
    assign io_write_byteMask_5 = wr_mask[5];
    assign io_write_byteMask_6 = wr_mask[6];
    assign io_write_byteMask_7 = wr_mask[7];
    assign io_count            = count;
    assign io_empty            = (count == '0);

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Bench for regfile_write_buffer: queue-based reference model plus directed checks.
// Honours REGFILE_WRITE_COALESCE_EN when the design is built with it.
module tb_regfile_write_buffer;

    localparam int DEPTH = 4;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_addr;
    logic [63:0] in_value;
    logic [7:0]  in_mask;
    logic        drain;
    logic        wr;
    logic [6:0]  wr_addr;
    logic [63:0] wr_value;
    logic        m0, m1, m2, m3, m4, m5, m6, m7;
    logic [2:0]  count;
    logic        empty;

    regfile_write_buffer #(.DEPTH(DEPTH), .ADDR_W(7), .DATA_W(64)) dut (
        .clock               (clock),
        .reset               (reset),
        .io_in_valid         (in_valid),
        .io_in_ready         (in_ready),
        .io_in_address       (in_addr),
        .io_in_value         (in_value),
        .io_in_byteMask      (in_mask),
        .io_drain_enable     (drain),
        .io_write_write      (wr),
        .io_write_address    (wr_addr),
        .io_write_value      (wr_value),
        .io_write_byteMask_0 (m0),
        .io_write_byteMask_1 (m1),
        .io_write_byteMask_2 (m2),
        .io_write_byteMask_3 (m3),
        .io_write_byteMask_4 (m4),
        .io_write_byteMask_5 (m5),
        .io_write_byteMask_6 (m6),
        .io_write_byteMask_7 (m7),
        .io_count            (count),
        .io_empty            (empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [6:0]  a;
        logic [63:0] v;
        logic [7:0]  m;
    } ent_t;

    ent_t        q[$];
    logic        exp_wr;
    ent_t        exp_out;
    int          n_vec;
    int          n_err;
    ent_t        log_q[$];
    logic [7:0]  dut_mask;

    assign dut_mask = {m7, m6, m5, m4, m3, m2, m1, m0};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending writes updated by the handshake rules.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            q.delete();
            exp_wr  = 1'b0;
            exp_out = '{a: '0, v: '0, m: '0};
        end else begin
            int   sz;
            bit   popping;
            ent_t hd;
            ent_t e;
            sz      = q.size();
            popping = drain && (sz > 0);
            if (popping) hd = q[0];
            if (in_valid && (sz != DEPTH) && (in_mask != 8'h00)) begin
                bit merged;
                merged = 1'b0;
`ifdef REGFILE_WRITE_COALESCE_EN
                if (sz > 0 && q[sz-1].a == in_addr && !(sz == 1 && popping)) begin
                    e = q[sz-1];
                    for (int i = 0; i < 8; i++)
                        if (in_mask[i]) e.v[8*i +: 8] = in_value[8*i +: 8];
                    e.m = e.m | in_mask;
                    q[sz-1] = e;
                    merged = 1'b1;
                end
`endif
                if (!merged) q.push_back('{a: in_addr, v: in_value, m: in_mask});
            end
            if (popping) begin
                void'(q.pop_front());
                exp_out = hd;
                exp_wr  = 1'b1;
            end else begin
                exp_wr  = 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        chk("write", {63'd0, wr}, {63'd0, exp_wr});
        chk("address", {57'd0, wr_addr}, {57'd0, exp_out.a});
        chk("value", wr_value, exp_out.v);
        chk("mask", {56'd0, dut_mask}, {56'd0, exp_out.m});
        chk("count", {61'd0, count}, 64'(q.size()));
        chk("empty", {63'd0, empty}, {63'd0, q.size() == 0});
        chk("ready", {63'd0, in_ready}, {63'd0, q.size() != DEPTH});
        if (wr) log_q.push_back('{a: wr_addr, v: wr_value, m: dut_mask});
    end

    task automatic step(input logic v, input logic [6:0] a, input logic [63:0] d,
                        input logic [7:0] m, input logic dr);
        in_valid = v;
        in_addr  = a;
        in_value = d;
        in_mask  = m;
        drain    = dr;
        @(posedge clock);
        #2;
    endtask

    task automatic idle(input logic dr, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 7'h0, 64'h0, 8'h00, dr);
    endtask

    task automatic chk_log(input int idx, input logic [6:0] a);
        if (idx < log_q.size()) chk("log_addr", {57'd0, log_q[idx].a}, {57'd0, a});
        else chk("log_missing", 64'(log_q.size()), 64'(idx + 1));
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_addr  = '0;
        in_value = '0;
        in_mask  = '0;
        drain    = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("rst_write", {63'd0, wr}, 64'd0);
        chk("rst_count", {61'd0, count}, 64'd0);
        chk("rst_empty", {63'd0, empty}, 64'd1);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clock);
        #2;

        // single write
        log_q.delete();
        step(1'b1, 7'h05, 64'h1122334455667788, 8'hFF, 1'b1);
        idle(1'b1, 3);
        chk("single_n", 64'(log_q.size()), 64'd1);
        chk_log(0, 7'h05);
        if (log_q.size() > 0) begin
            chk("single_val", log_q[0].v, 64'h1122334455667788);
            chk("single_mask", {56'd0, log_q[0].m}, 64'hFF);
        end

        // stall until full, then drain
        log_q.delete();
        for (int i = 1; i <= 4; i++) step(1'b1, 7'(i), 64'(i * 16'h0101), 8'h0F, 1'b0);
        step(1'b1, 7'h09, 64'h99, 8'hFF, 1'b0);
        chk("full_count", {61'd0, count}, 64'd4);
        chk("full_ready", {63'd0, in_ready}, 64'd0);
        idle(1'b1, 6);
        chk("stall_n", 64'(log_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk_log(i, 7'(i + 1));

        // zero mask is consumed without allocation
        log_q.delete();
        step(1'b1, 7'h10, 64'hDEAD, 8'h00, 1'b1);
        chk("zm_count", {61'd0, count}, 64'd0);
        idle(1'b1, 3);
        chk("zm_n", 64'(log_q.size()), 64'd0);

        // push and pop together at count 2
        log_q.delete();
        step(1'b1, 7'h21, 64'h21, 8'h01, 1'b0);
        step(1'b1, 7'h22, 64'h22, 8'h01, 1'b0);
        step(1'b1, 7'h23, 64'h23, 8'h01, 1'b1);
        chk("pp_count", {61'd0, count}, 64'd2);
        idle(1'b1, 4);
        chk_log(0, 7'h21);
        chk_log(1, 7'h22);
        chk_log(2, 7'h23);

        // same-address pair
        log_q.delete();
        step(1'b1, 7'h07, 64'h00000000000000AA, 8'h01, 1'b0);
        step(1'b1, 7'h07, 64'h000000000000BB00, 8'h02, 1'b0);
`ifdef REGFILE_WRITE_COALESCE_EN
        chk("co_count", {61'd0, count}, 64'd1);
        idle(1'b1, 3);
        chk("co_n", 64'(log_q.size()), 64'd1);
        if (log_q.size() > 0) begin
            chk("co_val", log_q[0].v, 64'h000000000000BBAA);
            chk("co_mask", {56'd0, log_q[0].m}, 64'h03);
        end
`else
        chk("co_count", {61'd0, count}, 64'd2);
        idle(1'b1, 3);
        chk("co_n", 64'(log_q.size()), 64'd2);
        if (log_q.size() > 1) begin
            chk("co_val0", log_q[0].v, 64'h00000000000000AA);
            chk("co_val1", log_q[1].v, 64'h000000000000BB00);
        end
`endif

        // reset mid-burst with three entries and a write in flight
        step(1'b1, 7'h31, 64'h31, 8'hFF, 1'b0);
        step(1'b1, 7'h32, 64'h32, 8'hFF, 1'b0);
        step(1'b1, 7'h33, 64'h33, 8'hFF, 1'b0);
        step(1'b1, 7'h34, 64'h34, 8'hFF, 1'b1);
        chk("mid_count", {61'd0, count}, 64'd3);
        chk("mid_write", {63'd0, wr}, 64'd1);
        reset = 1'b0;
        #1;
        chk("arst_count", {61'd0, count}, 64'd0);
        chk("arst_write", {63'd0, wr}, 64'd0);
        in_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        log_q.delete();
        idle(1'b1, 3);
        chk("post_rst_n", 64'(log_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_write_buffer.md
Name: regfile_write_buffer

Overview:
- Buffers register-file write requests from execution units and presents them, one per cycle, on a single registered write port of the register file.
- Sits directly upstream of one register-file write port (address, 64-bit value, eight byte-enables).
- Absorbs write-port stall cycles through a small FIFO; optionally coalesces back-to-back writes to the same register.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- ADDR_W, 7, register address width.
- DATA_W, 64, write value width; the byte count is fixed at 8.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_in_valid  in  1  write request valid.
- io_in_ready  out  1  buffer can accept a request this cycle.
- io_in_address  in  ADDR_W  target register.
- io_in_value  in  DATA_W  write data.
- io_in_byteMask  in  8  byte enables; bit i covers value[8i+7:8i].
- io_drain_enable  in  1  write port available this cycle.
- io_write_write  out  1  write strobe to the register file.
- io_write_address  out  ADDR_W  write address.
- io_write_value  out  DATA_W  write data.
- io_write_byteMask_0 .. io_write_byteMask_7  out  1 each  byte enables.
- io_count  out  log2(DEPTH)+1  occupied entries.
- io_empty  out  1  count == 0.

Behaviour:
- Reset:
  - Asserted (reset low) at any time, it immediately clears the FIFO, count and pointers.
  - Outputs during and after reset: io_write_write=0, io_write_address=0, io_write_value=0, all byte masks=0, io_count=0, io_empty=1.
  - Any in-flight write is dropped; no partial write is emitted.
- Handshake:
  - io_in_ready = (count != DEPTH). It depends only on state, never on io_in_valid or io_in_address.
  - A request is accepted on a rising edge where valid && ready.
- Zero mask: an accepted request with io_in_byteMask==0 is consumed and discarded. It allocates no entry and leaves count unchanged.
- Push: an accepted request with a nonzero mask is written at the tail. The tail pointer wraps modulo DEPTH.
- Pop: on each rising edge, if io_drain_enable && count>0:
  - The head entry is loaded into the output registers and io_write_write<=1.
  - The head pointer wraps modulo DEPTH.
  - Otherwise io_write_write<=0 and address/value/mask outputs hold their previous values.
- Latency: with an empty buffer and drain enabled, a request accepted at edge E0 drives io_write_write high from edge E1 to edge E2. The buffer has no combinational bypass.
- Simultaneous push and pop:
  - Both take effect; count is unchanged.
  - When full, ready=0, so no push occurs even while a pop frees an entry that cycle.
- Ordering: strict FIFO order; entries are never reordered.
- Stall: while io_drain_enable=0, entries accumulate until count==DEPTH. Ready then drops and stays low until the first pop edge.

Optional Feature:
- Macro: REGFILE_WRITE_COALESCE_EN.
- Defined:
  - An accepted nonzero-mask request whose address equals the youngest entry's address is merged into that entry instead of allocating.
  - Merge rule: for each set mask bit i, byte i is overwritten and mask bit i is set. Other bytes and bits are kept. Count is unchanged.
  - No merge occurs if the youngest entry is also the head being popped on the same edge (count==1 && pop). In that case a new entry is allocated.
  - Ready is still !full, so no merge is attempted when full.
- Undefined: every accepted nonzero-mask request allocates its own entry.

Test Plan:
- Reset: hold reset low 3 cycles then release -> io_write_write=0, io_count=0, io_empty=1, io_in_ready=1. Reassert mid-burst with count=3 -> count=0 and io_write_write=0 immediately.
- Single write, drain=1: push addr 0x05, value 0x1122334455667788, mask 0xFF -> exactly one cycle with io_write_write=1, address 0x05, same value, all masks=1, one edge after acceptance.
- Stall/full: drain=0, push addrs 1,2,3,4 -> count=4, ready=0, and a fifth valid is not accepted. Set drain=1 -> writes 1,2,3,4 in order on 4 consecutive cycles; ready=1 after the first pop.
- Zero mask: push addr 0x10 with mask 0x00 -> accepted (ready=1), count stays 0, and no write is emitted.
- Simultaneous push and pop at count=2 -> count stays 2 and order is preserved.
- Coalesce (macro defined), drain=0:
  - Push addr 0x07 value 0x00000000000000AA mask 0x01, then addr 0x07 value 0x000000000000BB00 mask 0x02 -> count=1. On drain, a single write of value 0x000000000000BBAA with byteMask_0=byteMask_1=1 and the rest 0.
  - Same stimulus without the macro -> count=2 and two separate writes.
